// File: rtl/fp_int_to_fp.sv
// fp_int_to_fp: sequential signed 16-bit integer to 13-bit float converter.
// Result format is {sign, exp[3:0], frac[7:0]}, value = (-1)^sign * 0.frac * 2^exp,
// with an explicit leading one in frac[7]. Normalization shifts one bit per cycle,
// followed by a single rounding cycle. Saturating results raise ovf.
module fp_int_to_fp #(
    parameter bit ROUND_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] int_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign_out,
    output logic [3:0]  exp_out,
    output logic [7:0]  frac_out,
    output logic        ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        sign_reg;
    logic [15:0] mag;
    logic [4:0]  exp_reg;

    // Rounding datapath, only consumed in ROUND
    logic [7:0]  frac_trunc;
    logic        guard_bit;
    logic        round_bit;
    logic        sticky_bit;
    logic        round_up;
    logic [8:0]  frac_sum;
    logic [7:0]  frac_rounded;
    logic [4:0]  exp_rounded;

    // Magnitude of the incoming integer; -32768 naturally wraps to 0x8000
    logic [15:0] abs_in;

    // Absolute value of the input word
    always_comb begin
        abs_in = int_in;
        if (int_in[15]) begin
            abs_in = (~int_in) + 16'd1;
        end
    end

    // Guard/round/sticky rounding with carry-out renormalization
    always_comb begin
        frac_trunc   = mag[15:8];
        guard_bit    = mag[7];
        round_bit    = mag[6];
        sticky_bit   = |mag[5:0];
        round_up     = ROUND_EN && guard_bit && (round_bit || sticky_bit || frac_trunc[0]);
        frac_sum     = {1'b0, frac_trunc} + {8'd0, round_up};
        frac_rounded = frac_trunc;
        exp_rounded  = exp_reg;
        if (frac_sum[8]) begin
            frac_rounded = 8'h80;
            exp_rounded  = exp_reg + 5'd1;
        end else begin
            frac_rounded = frac_sum[7:0];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = NORM;
                end
            end
            NORM: begin
                if ((mag == 16'd0) || mag[15]) begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture, shift-normalize, and load the rounded result
    always_ff @(posedge clk) begin
        if (reset) begin
            sign_reg <= 1'b0;
            mag      <= 16'd0;
            exp_reg  <= 5'd0;
            sign_out <= 1'b0;
            exp_out  <= 4'd0;
            frac_out <= 8'd0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_reg <= int_in[15];
                        mag      <= abs_in;
                        exp_reg  <= 5'd16;
                    end
                end
                NORM: begin
                    if ((mag != 16'd0) && !mag[15]) begin
                        mag     <= {mag[14:0], 1'b0};
                        exp_reg <= exp_reg - 5'd1;
                    end
                end
                ROUND: begin
                    if (mag == 16'd0) begin
                        sign_out <= 1'b0;
                        exp_out  <= 4'd0;
                        frac_out <= 8'd0;
                        ovf      <= 1'b0;
                    end else if (exp_rounded >= 5'd16) begin
                        sign_out <= sign_reg;
                        exp_out  <= 4'hF;
                        frac_out <= 8'hFF;
                        ovf      <= 1'b1;
                    end else begin
                        sign_out <= sign_reg;
                        exp_out  <= exp_rounded[3:0];
                        frac_out <= frac_rounded;
                        ovf      <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_int_to_fp.sv
// tb_fp_int_to_fp: directed self-checking bench for fp_int_to_fp.
// A second instance with rounding disabled shares all inputs with the main one.
module tb_fp_int_to_fp;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] int_in;
    logic        out_valid;
    logic        out_ready;
    logic        sign_out;
    logic [3:0]  exp_out;
    logic [7:0]  frac_out;
    logic        ovf;

    logic        tr_in_ready;
    logic        tr_out_valid;
    logic        tr_sign_out;
    logic [3:0]  tr_exp_out;
    logic [7:0]  tr_frac_out;
    logic        tr_ovf;

    int checks;
    int failures;
    int latency;

    fp_int_to_fp #(.ROUND_EN(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .int_in    (int_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign_out  (sign_out),
        .exp_out   (exp_out),
        .frac_out  (frac_out),
        .ovf       (ovf)
    );

    fp_int_to_fp #(.ROUND_EN(1'b0)) dut_trunc (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (tr_in_ready),
        .int_in    (int_in),
        .out_valid (tr_out_valid),
        .out_ready (out_ready),
        .sign_out  (tr_sign_out),
        .exp_out   (tr_exp_out),
        .frac_out  (tr_frac_out),
        .ovf       (tr_ovf)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Wait for IDLE, present one input for one edge, then count edges until out_valid
    task automatic applyStimulus(input logic [15:0] value);
        int waited;
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        in_valid = 1'b1;
        int_in   = value;
        @(posedge clk); #1;
        in_valid = 1'b0;
        int_in   = 16'hDEAD;
        latency  = 0;
        while (!out_valid && latency < 40) begin
            @(posedge clk); #1;
            latency++;
        end
    endtask

    task automatic checkResult(input string tag, input int lat, input logic s,
                               input logic [3:0] e, input logic [7:0] f, input logic o);
        checkOutput({tag, "_lat"},  latency, lat);
        checkOutput({tag, "_sign"}, sign_out, s);
        checkOutput({tag, "_exp"},  exp_out, e);
        checkOutput({tag, "_frac"}, frac_out, f);
        checkOutput({tag, "_ovf"},  ovf, o);
    endtask

    task automatic releaseResult();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        int_in    = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 1'b1);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_word", {sign_out, exp_out, frac_out, ovf}, 14'd0);
        reset = 1'b0;

        // Basic conversions, latency = leading zeros + 2
        applyStimulus(16'd1);
        checkResult("one", 17, 1'b0, 4'b0001, 8'b1000_0000, 1'b0);
        releaseResult();
        applyStimulus(-16'sd5);
        checkResult("neg5", 15, 1'b1, 4'b0011, 8'b1010_0000, 1'b0);
        releaseResult();
        applyStimulus(16'd0);
        checkResult("zero", 2, 1'b0, 4'b0000, 8'b0000_0000, 1'b0);
        releaseResult();
        applyStimulus(16'h8000);
        checkResult("min", 2, 1'b1, 4'b1111, 8'b1111_1111, 1'b1);
        releaseResult();

        // Rounding cases
        applyStimulus(16'd257);
        checkResult("r257", 9, 1'b0, 4'b1001, 8'b1000_0000, 1'b0);
        releaseResult();
        applyStimulus(16'd32640);
        checkResult("r32640", 3, 1'b0, 4'b1111, 8'b1111_1111, 1'b0);
        releaseResult();
        applyStimulus(16'd32767);
        checkResult("r32767", 3, 1'b0, 4'b1111, 8'b1111_1111, 1'b1);
        checkOutput("trunc_valid", tr_out_valid, 1'b1);
        checkOutput("trunc_word", {tr_sign_out, tr_exp_out, tr_frac_out, tr_ovf},
                    {1'b0, 4'b1111, 8'b1111_1111, 1'b0});
        releaseResult();

        // Backpressure on a round-up tie case, with an ignored input pulse
        applyStimulus(16'd259);
        checkResult("r259", 9, 1'b0, 4'b1001, 8'b1000_0010, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            int_in   = 16'd1;
            @(posedge clk); #1;
            checkOutput("bp_valid", out_valid, 1'b1);
            checkOutput("bp_in_ready", in_ready, 1'b0);
            checkOutput("bp_word", {sign_out, exp_out, frac_out, ovf},
                        {1'b0, 4'b1001, 8'b1000_0010, 1'b0});
        end
        in_valid = 1'b0;
        releaseResult();
        checkOutput("bp_rel_in_ready", in_ready, 1'b1);
        checkOutput("bp_rel_valid", out_valid, 1'b0);
        checkOutput("bp_rel_hold", {sign_out, exp_out, frac_out, ovf},
                    {1'b0, 4'b1001, 8'b1000_0010, 1'b0});
        @(posedge clk); #1;
        checkOutput("bp_idle_stays", out_valid, 1'b0);

        // Reset in the middle of normalization
        in_valid = 1'b1;
        int_in   = 16'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("mid_in_ready", in_ready, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("mid_rst_in_ready", in_ready, 1'b1);
        checkOutput("mid_rst_valid", out_valid, 1'b0);
        checkOutput("mid_rst_word", {sign_out, exp_out, frac_out, ovf}, 14'd0);
        applyStimulus(16'd3);
        checkResult("three", 16, 1'b0, 4'b0010, 8'b1100_0000, 1'b0);
        releaseResult();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
